switch_debouncer: RTL and testbench

Conditions the 24 raw board DIP switches before the CPU's switch read port samples them. The block synchronises every switch bit into the CPU clock domain and debounces it against a shared sample tick. It presents a stable 24-bit word, switch_input, to the switch read driver. It also flags which bits changed, for polling or interrupt logic.

---
 rtl/switch_debouncer.sv | 150 +++++++++++++++
 tb/tb_switch_debouncer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises raw DIP switch pins into the CPU clock
// domain, debounces each bit against a shared sample tick, and reports
// which debounced bits flipped with a one-cycle change pulse.
//
// Optional feature (macro SWITCH_STICKY_CHANGE_EN): adds a per-bit sticky
// change register (switch_sticky) with a per-bit clear input
// (switch_sticky_clr). A set and a clear in the same cycle leave the bit set.
//
// Parameter constraints: SYNC_STAGES >= 2, TICK_DIV >= 1, STABLE_COUNT >= 1.
module switch_debouncer #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 23000,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic             switclk,
  input  logic             switchrst_n,
  input  logic [WIDTH-1:0] switch_raw,
`ifdef SWITCH_STICKY_CHANGE_EN
  input  logic [WIDTH-1:0] switch_sticky_clr,
  output logic [WIDTH-1:0] switch_sticky,
`endif
  output logic [WIDTH-1:0] switch_input,
  output logic             switch_change,
  output logic [WIDTH-1:0] switch_change_mask,
  output logic             sample_tick
);

  // A one-state prescaler still needs a 1-bit counter to stay legal.
  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW  = $clog2(STABLE_COUNT) + 1;

  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  logic [PresW-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  logic [WIDTH-1:0] in_q, in_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             change_q, change_d;

  // Synchroniser chain: raw pins only ever land on the first stage.
  always_ff @(posedge switclk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= switch_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Prescaler next state: wrap at TICK_DIV-1, raise the tick the cycle after.
  always_comb begin
    presc_d = presc_q + PresW'(1);
    tick_d  = 1'b0;
    if (presc_q == PresMax) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge switclk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // Per-bit debounce: count consecutive ticks where sync disagrees with the
  // accepted level; any agreeing tick restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    in_d   = in_q;
    mask_d = '0;
    if (tick_q) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == in_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          cnt_d[i]  = '0;
          in_d[i]   = sync[i];
          mask_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    change_d = |mask_d;
  end

  // Debounce state and change pulse registers; pulse aligns with the update.
  always_ff @(posedge switclk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      in_q     <= '0;
      mask_q   <= '0;
      change_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      in_q     <= in_d;
      mask_q   <= mask_d;
      change_q <= change_d;
    end
  end

`ifdef SWITCH_STICKY_CHANGE_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;

  // Sticky next state: a flip in the same cycle as a clear must not be lost.
  always_comb begin
    sticky_d = (sticky_q & ~switch_sticky_clr) | mask_d;
  end

  // Sticky change register.
  always_ff @(posedge switclk or negedge switchrst_n) begin
    if (!switchrst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign switch_sticky = sticky_q;
`endif

  assign switch_input       = in_q;
  assign switch_change      = change_q;
  assign switch_change_mask = mask_q;
  assign sample_tick        = tick_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer. Instance A runs with
// TICK_DIV=4/STABLE_COUNT=3, instance B with TICK_DIV=1/STABLE_COUNT=1.
module tb_switch_debouncer;

  localparam int unsigned W = 24;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] raw_a, raw_b;
  logic [W-1:0] in_a, in_b;
  logic         chg_a, chg_b;
  logic [W-1:0] mask_a, mask_b;
  logic         tick_a, tick_b;
`ifdef SWITCH_STICKY_CHANGE_EN
  logic [W-1:0] clr_a, clr_b;
  logic [W-1:0] sticky_a, sticky_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pulses_a = 0;
  int idle_bad = 0;
  logic [W-1:0] last_mask_a = '0;

  switch_debouncer #(
    .WIDTH(W), .SYNC_STAGES(2), .TICK_DIV(4), .STABLE_COUNT(3)
  ) u_dut_a (
    .switclk           (clk),
    .switchrst_n       (rst_n),
    .switch_raw        (raw_a),
`ifdef SWITCH_STICKY_CHANGE_EN
    .switch_sticky_clr (clr_a),
    .switch_sticky     (sticky_a),
`endif
    .switch_input      (in_a),
    .switch_change     (chg_a),
    .switch_change_mask(mask_a),
    .sample_tick       (tick_a)
  );

  switch_debouncer #(
    .WIDTH(W), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_COUNT(1)
  ) u_dut_b (
    .switclk           (clk),
    .switchrst_n       (rst_n),
    .switch_raw        (raw_b),
`ifdef SWITCH_STICKY_CHANGE_EN
    .switch_sticky_clr (clr_b),
    .switch_sticky     (sticky_b),
`endif
    .switch_input      (in_b),
    .switch_change     (chg_b),
    .switch_change_mask(mask_b),
    .sample_tick       (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor for instance A.
  always @(negedge clk) begin
    if (chg_a) begin
      pulses_a    = pulses_a + 1;
      last_mask_a = mask_a;
    end
    if (!chg_a && mask_a != '0) idle_bad = idle_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until n sample ticks of instance A have been seen (bounded).
  task automatic wait_ticks(input int n);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      step(1);
      if (tick_a) got++;
    end
    chk("tick_wait", got, n);
  endtask

  int  base;
  int  lat;
  bit  found;

  initial begin
    rst_n = 1'b0;
    raw_a = 24'hFFFFFF;
    raw_b = 24'hFFFFFF;
`ifdef SWITCH_STICKY_CHANGE_EN
    clr_a = '0;
    clr_b = '0;
`endif
    // 1. Reset held with all raw pins high.
    step(4);
    chk("rst_in_a", in_a, 0);
    chk("rst_chg_a", chg_a, 0);
    chk("rst_mask_a", mask_a, 0);
    chk("rst_tick_a", tick_a, 0);
    chk("rst_in_b", in_b, 0);
    chk("rst_tick_b", tick_b, 0);

    raw_a = '0;
    raw_b = '0;
    step(1);
    rst_n = 1'b1;
    step(25);
    chk("idle_in_a", in_a, 0);
    chk("tick_b_on", tick_b, 1);

    // 2. Clean step, latency window 11..15 cycles.
    base  = pulses_a;
    raw_a = 24'h00A5C3;
    found = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (!found && in_a == 24'h00A5C3) begin
        found = 1'b1;
        lat   = c;
      end
    end
    chk("step_found", found, 1);
    chk("step_lat_window", (lat >= 11 && lat <= 15), 1);
    chk("step_pulses", pulses_a - base, 1);
    chk("step_mask", last_mask_a, 24'h00A5C3);
    chk("step_in", in_a, 24'h00A5C3);

    // 3. Bounce on bit 16: never three consecutive agreeing ticks.
    base = pulses_a;
    for (int k = 0; k < 8; k++) begin
      raw_a[16] = ~raw_a[16];
      step(5);
    end
    chk("bounce_no_pulse", pulses_a - base, 0);
    chk("bounce_in_hold", in_a, 24'h00A5C3);
    raw_a[16] = 1'b1;
    step(20);
    chk("bounce_one_pulse", pulses_a - base, 1);
    chk("bounce_mask", last_mask_a, 24'h010000);
    chk("bounce_in", in_a, 24'h01A5C3);

    // 4. Simultaneous rising and falling bits.
    raw_a = 24'hFF0000;
    step(20);
    chk("pre_simul_in", in_a, 24'hFF0000);
    chk("pre_simul_mask", last_mask_a, 24'hFEA5C3);
    base  = pulses_a;
    raw_a = 24'h00FF00;
    step(20);
    chk("simul_pulses", pulses_a - base, 1);
    chk("simul_mask", last_mask_a, 24'hFFFF00);
    chk("simul_in", in_a, 24'h00FF00);

    // Asynchronous reset between clock edges clears outputs at once.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in", in_a, 0);
    chk("async_rst_chg", chg_a, 0);
    chk("async_rst_tick", tick_a, 0);
    raw_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(10);

    // 5. Reset mid-debounce discards partial counts.
    raw_a = 24'h000001;
    wait_ticks(2);
    step(1);
    chk("mid_pre_rst", in_a, 0);
    rst_n = 1'b0;
    step(2);
    chk("mid_in_rst", in_a, 0);
    rst_n = 1'b1;
    wait_ticks(2);
    step(1);
    chk("mid_after_2", in_a[0], 0);
    wait_ticks(1);
    chk("mid_at_3", in_a[0], 0);
    step(1);
    chk("mid_after_3", in_a[0], 1);

    // 6. TICK_DIV=1, STABLE_COUNT=1: accept exactly 3 cycles after the edge.
    raw_b = 24'h000020;
    step(2);
    chk("fast_early", in_b, 0);
    step(1);
    chk("fast_in", in_b, 24'h000020);
    chk("fast_chg", chg_b, 1);
    chk("fast_mask", mask_b, 24'h000020);
    step(1);
    chk("fast_chg_off", chg_b, 0);
    chk("fast_mask_off", mask_b, 0);
`ifdef SWITCH_STICKY_CHANGE_EN
    chk("sticky_set", sticky_b, 24'h000020);
    step(3);
    chk("sticky_hold", sticky_b, 24'h000020);
    clr_b = 24'h000020;
    step(1);
    clr_b = '0;
    chk("sticky_clr", sticky_b, 0);
`endif
    raw_b = '0;
    step(2);
`ifdef SWITCH_STICKY_CHANGE_EN
    clr_b = 24'h000020;
`endif
    step(1);
`ifdef SWITCH_STICKY_CHANGE_EN
    clr_b = '0;
    chk("sticky_set_wins", sticky_b, 24'h000020);
`endif
    chk("fast_fall", in_b, 0);
    chk("fast_fall_mask", mask_b, 24'h000020);

    chk("mask_idle_zero", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
